// File: rtl/hba_quad_pkg.sv
// Shared register map, control bit positions and quadrature step decoding.
// Combinational helpers only; no latency or flow control.
package hba_quad_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_CH_EN     = 1;
    localparam int REG_INVERT    = 2;
    localparam int REG_ERR       = 3;
    localparam int REG_SNAP_BASE = 4;

    localparam int CTRL_INTR_EN = 0;
    localparam int CTRL_SNAP    = 1;
    localparam int CTRL_CLR     = 2;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_INC     = 2'd1,
        STEP_DEC     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // ab = {A,B}. The forward sequence 00,10,11,01 maps to phase 0,1,2,3,
    // so a phase difference of 1 is +1, 3 is -1 and 2 means both pins moved.
    function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] p_phase;
        logic [1:0] c_phase;
        logic [1:0] diff;
        p_phase = {prev_ab[0], ^prev_ab};
        c_phase = {cur_ab[0], ^cur_ab};
        diff    = c_phase - p_phase;
        case (diff)
            2'd1:    decode_step = STEP_INC;
            2'd3:    decode_step = STEP_DEC;
            2'd2:    decode_step = STEP_ILLEGAL;
            default: decode_step = STEP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/quad_chan.sv
// One encoder channel: 2-flop sync, glitch filter, x4 decoder, up/down counter.
// Pin edge to count update is 3+FILTER_LEN cycles; no backpressure.
module quad_chan
    import hba_quad_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int FILTER_LEN  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   en,
    input  logic                   invert,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] count,
    output step_t                  step,
    output logic                   err_pulse
);

    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       filt_q, filt_d;
    logic [1:0][3:0]  flt_cnt_q, flt_cnt_d;
    logic [1:0]       prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    step_t            raw_step;

    always_comb begin
        sync1_d   = {enc_a, enc_b};
        sync2_d   = sync1_q;
        filt_d    = filt_q;
        flt_cnt_d = flt_cnt_q;
        // A pin is accepted only once it has disagreed for FILTER_LEN cycles in a row.
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (flt_cnt_q[i] == 4'(FILTER_LEN - 1)) begin
                    filt_d[i]    = sync2_q[i];
                    flt_cnt_d[i] = 4'd0;
                end else begin
                    flt_cnt_d[i] = flt_cnt_q[i] + 4'd1;
                end
            end else begin
                flt_cnt_d[i] = 4'd0;
            end
        end

        prev_d    = filt_q;
        raw_step  = decode_step(prev_q, filt_q);
        step      = STEP_NONE;
        err_pulse = 1'b0;
        if (en) begin
            case (raw_step)
                STEP_INC:     step = invert ? STEP_DEC : STEP_INC;
                STEP_DEC:     step = invert ? STEP_INC : STEP_DEC;
                STEP_ILLEGAL: err_pulse = 1'b1;
                default:      step = STEP_NONE;
            endcase
        end

        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (step == STEP_INC) begin
            count_d = count_q + 1'b1;
        end else if (step == STEP_DEC) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            flt_cnt_q <= '0;
            prev_q    <= '0;
            count_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            prev_q    <= prev_d;
            count_q   <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hba_quad_multi.sv
// HBA slave for NUM_CH quadrature counters with atomic snapshot and level interrupt.
// One-cycle registered ack after address match; never stalls the bus.
module hba_quad_multi
    import hba_quad_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0,
    parameter int NUM_CH            = 2,
    parameter int COUNT_WIDTH       = 16,
    parameter int FILTER_LEN        = 2
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    input  logic                  hba_rnw,
    input  logic                  hba_select,
    input  logic [ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
    output logic                  hba_xferack_slave,
    output logic                  slave_interrupt,
    input  logic [NUM_CH-1:0]     quad_enc_a,
    input  logic [NUM_CH-1:0]     quad_enc_b
);

    localparam int CB = COUNT_WIDTH / 8;

    logic                  ack_q, ack_d;
    logic [DBUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                  intr_en_q, intr_en_d;
    logic                  changed_q, changed_d;
    logic [NUM_CH-1:0]     ch_en_q, ch_en_d;
    logic [NUM_CH-1:0]     invert_q, invert_d;
    logic [NUM_CH-1:0]     err_q, err_d;
    logic [NUM_CH-1:0][COUNT_WIDTH-1:0] snap_q, snap_d;

    logic [NUM_CH-1:0][COUNT_WIDTH-1:0] count;
    step_t                 step [NUM_CH];
    logic [NUM_CH-1:0]     err_pulse;

    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic                  match, wr;
    logic                  wr_ctrl, snap_req, clr_req;
    logic                  any_step;
    logic [DBUS_WIDTH-1:0] rd_val;

    assign reg_addr = hba_abus[REG_ADDR_WIDTH-1:0];
    // Gating on ack_q keeps a held select from producing back-to-back acks.
    assign match    = hba_select && !ack_q &&
                      (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    assign wr       = match && !hba_rnw;
    assign wr_ctrl  = wr && (reg_addr == REG_ADDR_WIDTH'(REG_CTRL));
    assign snap_req = wr_ctrl && hba_dbus[CTRL_SNAP];
    assign clr_req  = wr_ctrl && hba_dbus[CTRL_CLR];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        quad_chan #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk       (hba_clk),
            .rst       (hba_reset),
            .enc_a     (quad_enc_a[ch]),
            .enc_b     (quad_enc_b[ch]),
            .en        (ch_en_q[ch]),
            .invert    (invert_q[ch]),
            .clr       (clr_req),
            .count     (count[ch]),
            .step      (step[ch]),
            .err_pulse (err_pulse[ch])
        );
    end

    always_comb begin
        rd_val = '0;
        if (reg_addr == REG_ADDR_WIDTH'(REG_CTRL)) begin
            rd_val[CTRL_INTR_EN] = intr_en_q;
        end else if (reg_addr == REG_ADDR_WIDTH'(REG_CH_EN)) begin
            rd_val = DBUS_WIDTH'(ch_en_q);
        end else if (reg_addr == REG_ADDR_WIDTH'(REG_INVERT)) begin
            rd_val = DBUS_WIDTH'(invert_q);
        end else if (reg_addr == REG_ADDR_WIDTH'(REG_ERR)) begin
            rd_val = DBUS_WIDTH'(err_q);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int b = 0; b < CB; b++) begin
                if (reg_addr == REG_ADDR_WIDTH'(REG_SNAP_BASE + ch * CB + b)) begin
                    rd_val = snap_q[ch][b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        ack_d     = match;
        rdata_d   = (match && hba_rnw) ? rd_val : '0;
        intr_en_d = wr_ctrl ? hba_dbus[CTRL_INTR_EN] : intr_en_q;
        ch_en_d   = (wr && reg_addr == REG_ADDR_WIDTH'(REG_CH_EN))  ? hba_dbus[NUM_CH-1:0] : ch_en_q;
        invert_d  = (wr && reg_addr == REG_ADDR_WIDTH'(REG_INVERT)) ? hba_dbus[NUM_CH-1:0] : invert_q;

        err_d = err_q;
        if (wr && reg_addr == REG_ADDR_WIDTH'(REG_ERR)) begin
            err_d = err_d & ~hba_dbus[NUM_CH-1:0];
        end
        if (clr_req) begin
            err_d = '0;
        end
        err_d = err_d | err_pulse;

        // Snapshot reads the registered counts, so a coincident step lands after it.
        snap_d   = snap_q;
        any_step = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (snap_req) begin
                snap_d[ch] = count[ch];
            end
            if (step[ch] != STEP_NONE) begin
                any_step = 1'b1;
            end
        end
        changed_d = (changed_q && !snap_req) || any_step;
    end

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            intr_en_q <= 1'b0;
            changed_q <= 1'b0;
            ch_en_q   <= '0;
            invert_q  <= '0;
            err_q     <= '0;
            snap_q    <= '0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            intr_en_q <= intr_en_d;
            changed_q <= changed_d;
            ch_en_q   <= ch_en_d;
            invert_q  <= invert_d;
            err_q     <= err_d;
            snap_q    <= snap_d;
        end
    end

    assign hba_xferack_slave = ack_q;
    assign hba_dbus_slave    = rdata_q;
    assign slave_interrupt   = intr_en_q & changed_q;

    // Upper data bits are only meaningful for some registers.
    logic unused_dbus;
    assign unused_dbus = ^hba_dbus;

endmodule

// File: tb/tb_hba_quad_multi.sv
// Directed bench: bus transfers push expected read data; a negedge monitor pops on ack.
module tb_hba_quad_multi;

    localparam int NUM_CH = 2;

    logic        hba_clk = 1'b0;
    logic        hba_reset;
    logic        hba_rnw;
    logic        hba_select;
    logic [11:0] hba_abus;
    logic [7:0]  hba_dbus;
    logic [7:0]  hba_dbus_slave;
    logic        hba_xferack_slave;
    logic        slave_interrupt;
    logic [NUM_CH-1:0] quad_enc_a;
    logic [NUM_CH-1:0] quad_enc_b;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    int pos [NUM_CH];

    hba_quad_multi dut (
        .hba_clk           (hba_clk),
        .hba_reset         (hba_reset),
        .hba_rnw           (hba_rnw),
        .hba_select        (hba_select),
        .hba_abus          (hba_abus),
        .hba_dbus          (hba_dbus),
        .hba_dbus_slave    (hba_dbus_slave),
        .hba_xferack_slave (hba_xferack_slave),
        .slave_interrupt   (slave_interrupt),
        .quad_enc_a        (quad_enc_a),
        .quad_enc_b        (quad_enc_b)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write transfers expect zero read data during their ack.
    task automatic bus(input logic rnw, input logic [11:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp);
        exp_q.push_back(rnw ? exp : 8'h00);
        @(posedge hba_clk); #1;
        hba_select = 1'b1; hba_rnw = rnw; hba_abus = addr; hba_dbus = wd;
        @(posedge hba_clk); #1;
        hba_select = 1'b0; hba_rnw = 1'b1; hba_dbus = 8'h00;
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0:       gray = 2'b00;
            1:       gray = 2'b10;
            2:       gray = 2'b11;
            default: gray = 2'b01;
        endcase
    endfunction

    task automatic set_pins(input int ch, input logic [1:0] ab);
        quad_enc_a[ch] = ab[1];
        quad_enc_b[ch] = ab[0];
    endtask

    // Pins change just after a rising edge; the caller then waits.
    task automatic enc_step(input int ch, input bit fwd);
        logic [1:0] ab;
        @(posedge hba_clk); #1;
        pos[ch] = fwd ? (pos[ch] + 1) % 4 : (pos[ch] + 3) % 4;
        ab = gray(pos[ch]);
        set_pins(ch, ab);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge hba_clk);
    endtask

    // Monitor: ack must be one cycle wide, carry the queued data, and data is zero otherwise.
    initial begin
        logic prev_ack;
        logic [7:0] e;
        prev_ack = 1'b0;
        forever begin
            @(negedge hba_clk);
            if (hba_reset) begin
                prev_ack = 1'b0;
            end else begin
                if (hba_xferack_slave) begin
                    if (prev_ack) begin
                        miscompares++;
                        $display("FAIL ack_width: got ack on consecutive cycles, expected single pulse");
                    end
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_ack: got ack, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_data", hba_dbus_slave, e);
                    end
                end else if (hba_dbus_slave !== 8'h00) begin
                    miscompares++;
                    $display("FAIL idle_data: got 0x%0h, expected 0x00", hba_dbus_slave);
                end
                prev_ack = hba_xferack_slave;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hba_reset = 1'b1; hba_rnw = 1'b1; hba_select = 1'b0;
        hba_abus = '0; hba_dbus = '0; quad_enc_a = '0; quad_enc_b = '0;
        pos[0] = 0; pos[1] = 0;
        idle(3); #1;
        chk("rst_ack", hba_xferack_slave, 0);
        chk("rst_data", hba_dbus_slave, 0);
        chk("rst_intr", slave_interrupt, 0);
        hba_reset = 1'b0;

        // Reset state of the register file, plus unmapped and foreign-peripheral addresses.
        for (int r = 0; r < 8; r++) bus(1'b1, 12'(r), 8'h00, 8'h00);
        bus(1'b0, 12'h0FF, 8'hFF, 8'h00);
        bus(1'b1, 12'h0FF, 8'h00, 8'h00);
        @(posedge hba_clk); #1;
        hba_select = 1'b1; hba_abus = 12'h101;
        @(posedge hba_clk); #1;
        hba_select = 1'b0;
        idle(2);

        // Twelve forward steps on ch0; the first one also times the interrupt.
        bus(1'b0, 12'h001, 8'h01, 8'h00);
        bus(1'b0, 12'h000, 8'h01, 8'h00);
        enc_step(0, 1'b1);
        idle(4); #1;
        chk("lat_cycle4", slave_interrupt, 0);
        idle(1); #1;
        chk("lat_cycle5", slave_interrupt, 1);
        idle(8);
        for (int s = 1; s < 12; s++) begin
            enc_step(0, 1'b1);
            idle(10);
        end
        bus(1'b0, 12'h000, 8'h03, 8'h00);
        #1 chk("intr_after_snap", slave_interrupt, 0);
        bus(1'b1, 12'h004, 8'h00, 8'h0C);
        bus(1'b1, 12'h005, 8'h00, 8'h00);

        // Reverse step on ch1 wraps to all-ones; with invert the same direction counts up.
        bus(1'b0, 12'h001, 8'h03, 8'h00);
        enc_step(1, 1'b0);
        idle(10);
        bus(1'b0, 12'h000, 8'h03, 8'h00);
        bus(1'b1, 12'h006, 8'h00, 8'hFF);
        bus(1'b1, 12'h007, 8'h00, 8'hFF);
        bus(1'b0, 12'h002, 8'h02, 8'h00);
        enc_step(1, 1'b0);
        idle(10);
        bus(1'b0, 12'h000, 8'h03, 8'h00);
        bus(1'b1, 12'h006, 8'h00, 8'h00);
        bus(1'b1, 12'h007, 8'h00, 8'h00);
        bus(1'b1, 12'h002, 8'h00, 8'h02);

        // One-cycle glitch is filtered; a double-pin change flags an error without counting.
        @(posedge hba_clk); #1;
        quad_enc_a[0] = 1'b1;
        @(posedge hba_clk); #1;
        quad_enc_a[0] = 1'b0;
        idle(10);
        @(posedge hba_clk); #1;
        set_pins(0, 2'b11);
        pos[0] = 2;
        idle(10);
        bus(1'b0, 12'h000, 8'h03, 8'h00);
        bus(1'b1, 12'h004, 8'h00, 8'h0C);
        bus(1'b1, 12'h003, 8'h00, 8'h01);
        bus(1'b0, 12'h003, 8'h01, 8'h00);
        bus(1'b1, 12'h003, 8'h00, 8'h00);

        // Interrupt on an enabled step, cleared by SNAP; disabled channel stays silent.
        #1 chk("intr_quiet", slave_interrupt, 0);
        enc_step(0, 1'b1);
        idle(4); #1;
        chk("intr_cycle4", slave_interrupt, 0);
        idle(1); #1;
        chk("intr_cycle5", slave_interrupt, 1);
        bus(1'b0, 12'h000, 8'h03, 8'h00);
        #1 chk("intr_snap_clear", slave_interrupt, 0);
        bus(1'b0, 12'h001, 8'h01, 8'h00);
        enc_step(1, 1'b1);
        idle(10); #1;
        chk("intr_disabled_ch", slave_interrupt, 0);

        // Clear, count to 5, then SNAP+CLR in one write.
        bus(1'b0, 12'h000, 8'h05, 8'h00);
        for (int s = 0; s < 5; s++) begin
            enc_step(0, 1'b1);
            idle(10);
        end
        bus(1'b0, 12'h000, 8'h06, 8'h00);
        #1 chk("intr_off", slave_interrupt, 0);
        bus(1'b1, 12'h004, 8'h00, 8'h05);
        bus(1'b1, 12'h005, 8'h00, 8'h00);
        bus(1'b1, 12'h006, 8'h00, 8'h00);
        bus(1'b1, 12'h000, 8'h00, 8'h00);
        bus(1'b0, 12'h000, 8'h02, 8'h00);
        bus(1'b1, 12'h004, 8'h00, 8'h00);
        bus(1'b1, 12'h005, 8'h00, 8'h00);

        // Reset during the ack cycle of a read of CH_EN.
        @(posedge hba_clk); #1;
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h001;
        @(posedge hba_clk); #1;
        hba_select = 1'b0;
        chk("pre_rst_ack", hba_xferack_slave, 1);
        chk("pre_rst_data", hba_dbus_slave, 8'h01);
        #2 hba_reset = 1'b1;
        #1;
        chk("mid_rst_ack", hba_xferack_slave, 0);
        chk("mid_rst_data", hba_dbus_slave, 8'h00);
        @(posedge hba_clk); #1;
        hba_reset = 1'b0;
        bus(1'b1, 12'h001, 8'h00, 8'h00);
        bus(1'b1, 12'h004, 8'h00, 8'h00);

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
